// File: rtl/sprite_pkg.sv
// Shared types and constants for the scanline sprite renderers.
// State encoding, ROM fetch latency and counter-width helper.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LINE_CHK,
    WAIT_POS,
    DRAW,
    LINE_END,
    DONE
  } state_e;

  // Cycles from address issue to data at the pixel output: address register, then ROM register.
  localparam int unsigned FETCH_LAT = 2;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_draw.sv
// Scanline sprite renderer driving a synchronous sprite ROM; one instance per on-screen sprite.
// Define SPRITE_FLIP_EN to add a frame-sampled horizontal mirror input (flip).
module sprite_draw
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W   = 8,
  parameter int unsigned SPR_H   = 8,
  parameter int unsigned SCALE_X = 1,
  parameter int unsigned SCALE_Y = 1,
  parameter int unsigned COLRW   = 4,
  parameter int unsigned CORDW   = 16,
  parameter int unsigned ADDRW   = $clog2(SPR_W * SPR_H),
  parameter int unsigned TRANSP  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    line,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic signed [CORDW-1:0] sprx,
  input  logic signed [CORDW-1:0] spry,
`ifdef SPRITE_FLIP_EN
  input  logic                    flip,
`endif
  output logic [ADDRW-1:0]        rom_addr,
  input  logic [COLRW-1:0]        rom_data,
  output logic [COLRW-1:0]        pix,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned OXW = cnt_w(SPR_W);
  localparam int unsigned OYW = cnt_w(SPR_H);
  localparam int unsigned CXW = cnt_w(SCALE_X);
  localparam int unsigned CYW = cnt_w(SCALE_Y);
  localparam int unsigned CW1 = CORDW + 1;

  state_e                  state_q, state_d;
  logic [ADDRW-1:0]        rom_addr_q, rom_addr_d;
  logic [OXW-1:0]          ox_q, ox_d;
  logic [CXW-1:0]          cx_q, cx_d;
  logic [OYW-1:0]          oy_q, oy_d;
  logic [CYW-1:0]          cy_q, cy_d;
  logic signed [CORDW-1:0] sprx_q, spry_q;
  logic                    armed_q, armed_d;
  logic                    pix_vld_q, pix_vld_d;
  logic                    done_q, done_d;

  // Extended by one bit so the edge arithmetic cannot overflow at the coordinate extremes.
  logic signed [CORDW:0] sx_e, sy_e, x_start, y_top, y_bot;
  logic                  in_rows;
  logic [ADDRW-1:0]      row_base, row_start, addr_next;

  assign sx_e    = $signed({sx[CORDW-1], sx});
  assign sy_e    = $signed({sy[CORDW-1], sy});
  assign y_top   = $signed({spry_q[CORDW-1], spry_q});
  assign x_start = $signed({sprx_q[CORDW-1], sprx_q}) - CW1'(FETCH_LAT);
  assign y_bot   = y_top + CW1'(SPR_H * SCALE_Y);
  assign in_rows = (sy_e >= y_top) && (sy_e < y_bot);

  assign row_base = ADDRW'(oy_q * SPR_W);

`ifdef SPRITE_FLIP_EN
  logic flip_q;
  assign row_start = flip_q ? row_base + ADDRW'(SPR_W - 1) : row_base;
  assign addr_next = flip_q ? rom_addr_q - ADDRW'(1) : rom_addr_q + ADDRW'(1);
`else
  assign row_start = row_base;
  assign addr_next = rom_addr_q + ADDRW'(1);
`endif

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    ox_d       = ox_q;
    cx_d       = cx_q;
    oy_d       = oy_q;
    cy_d       = cy_q;
    armed_d    = armed_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line) state_d = LINE_CHK;
      end
      LINE_CHK: begin
        state_d = (armed_q && in_rows) ? WAIT_POS : IDLE;
      end
      WAIT_POS: begin
        if (line) begin
          state_d = LINE_CHK;
        end else if (sx_e == x_start) begin
          rom_addr_d = row_start;
          ox_d       = '0;
          cx_d       = '0;
          state_d    = DRAW;
        end
      end
      DRAW: begin
        if (line) begin
          state_d = LINE_CHK;
        end else if (cx_q == CXW'(SCALE_X - 1)) begin
          cx_d = '0;
          if (ox_q == OXW'(SPR_W - 1)) begin
            state_d = LINE_END;
          end else begin
            ox_d       = ox_q + OXW'(1);
            rom_addr_d = addr_next;
          end
        end else begin
          cx_d = cx_q + CXW'(1);
        end
      end
      LINE_END: begin
        state_d = IDLE;
        if (cy_q == CYW'(SCALE_Y - 1)) begin
          cy_d = '0;
          if (oy_q == OYW'(SPR_H - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            oy_d = oy_q + OYW'(1);
          end
        end else begin
          cy_d = cy_q + CYW'(1);
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // Frame overrides everything; a coincident line pulse is checked against the new position.
    if (frame) begin
      state_d    = line ? LINE_CHK : IDLE;
      rom_addr_d = '0;
      ox_d       = '0;
      cx_d       = '0;
      oy_d       = '0;
      cy_d       = '0;
      armed_d    = 1'b1;
      done_d     = 1'b0;
    end
  end

  // ROM data for the address held during DRAW arrives one cycle later.
  assign pix_vld_d = (state_q == DRAW) && !line && !frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      ox_q       <= '0;
      cx_q       <= '0;
      oy_q       <= '0;
      cy_q       <= '0;
      sprx_q     <= '0;
      spry_q     <= '0;
      armed_q    <= 1'b0;
      pix_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      ox_q       <= ox_d;
      cx_q       <= cx_d;
      oy_q       <= oy_d;
      cy_q       <= cy_d;
      armed_q    <= armed_d;
      pix_vld_q  <= pix_vld_d;
      done_q     <= done_d;
      if (frame) begin
        sprx_q <= sprx;
        spry_q <= spry;
      end
    end
  end

`ifdef SPRITE_FLIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flip_q <= 1'b0;
    else if (frame) flip_q <= flip;
  end
`endif

  assign rom_addr = rom_addr_q;
  assign pix      = pix_vld_q ? rom_data : '0;
  assign drawing  = pix_vld_q && (rom_data != COLRW'(TRANSP));
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Scoreboard bench: two renderers (scale 1x1 and 2x3) share scan timing and sprite position.
// Expected pixels come from a geometric model of the sprite window; ROMs are modelled in the bench.
module tb_sprite_draw;

  localparam int W = 8;
  localparam int H = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame = 1'b0;
  logic               line = 1'b0;
  logic               flip = 1'b0;
  logic signed [15:0] sx = '0, sy = '0, sprx = '0, spry = '0;
  logic [5:0]         addr1, addr2;
  logic [3:0]         rd1, rd2, pix1, pix2;
  logic               drw1, drw2, done1, done2;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] p1;
    logic       d1;
    logic       dn1;
    logic [3:0] p2;
    logic       d2;
    logic       dn2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state
  int scx[2] = '{1, 2};
  int scy[2] = '{1, 3};
  int mrow[2], mrep[2], carry_col[2], carry_row[2];
  bit fin[2];
  bit armed = 1'b0;
  bit m_flip = 1'b0;
  int m_sprx = 0, m_spry = 0;

  function automatic logic [3:0] rom_val(input int a);
    int r, c;
    r = a / W;
    c = a % W;
    if (c == 3) return 4'd0;
    return 4'((r * 3 + c) % 15 + 1);
  endfunction

  function automatic logic [3:0] exp_pix(input int row, input int col);
    int c;
    c = m_flip ? (W - 1 - col) : col;
    return rom_val(row * W + c);
  endfunction

  always @(posedge clk) begin
    rd1 <= rom_val(int'(addr1));
    rd2 <= rom_val(int'(addr2));
  end

  sprite_draw #(.SPR_W(8), .SPR_H(8), .SCALE_X(1), .SCALE_Y(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .line     (line),
    .sx       (sx),
    .sy       (sy),
    .sprx     (sprx),
    .spry     (spry),
`ifdef SPRITE_FLIP_EN
    .flip     (flip),
`endif
    .rom_addr (addr1),
    .rom_data (rd1),
    .pix      (pix1),
    .drawing  (drw1),
    .done     (done1)
  );

  sprite_draw #(.SPR_W(8), .SPR_H(8), .SCALE_X(2), .SCALE_Y(3)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .line     (line),
    .sx       (sx),
    .sy       (sy),
    .sprx     (sprx),
    .spry     (spry),
`ifdef SPRITE_FLIP_EN
    .flip     (flip),
`endif
    .rom_addr (addr2),
    .rom_data (rd2),
    .pix      (pix2),
    .drawing  (drw2),
    .done     (done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (sx=%0d sy=%0d t=%0t)", tag, obs, exp_v, sx, sy,
               $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pix1", pix1, e.p1);
      check("drawing1", drw1, e.d1);
      check("done1", done1, e.dn1);
      check("pix2", pix2, e.p2);
      check("drawing2", drw2, e.d2);
      check("done2", done2, e.dn2);
    end
  end

  task automatic drive_cycle(input int x, input int y, input bit f, input bit l, input exp_t e);
    @(posedge clk);
    #1;
    sx    = 16'(x);
    sy    = 16'(y);
    frame = f;
    line  = l;
    q.push_back(e);
  endtask

  task automatic set_pos(input int x, input int y, input bit f);
    sprx   = 16'(x);
    spry   = 16'(y);
    flip   = f;
    m_sprx = x;
    m_spry = y;
`ifdef SPRITE_FLIP_EN
    m_flip = f;
`else
    m_flip = 1'b0;
`endif
  endtask

  task automatic model_frame();
    for (int k = 0; k < 2; k++) begin
      mrow[k] = 0;
      mrep[k] = 0;
      fin[k]  = 1'b0;
    end
    armed = 1'b1;
  endtask

  task automatic do_frame();
    exp_t e;
    e = '{p1: 4'd0, d1: 1'b0, dn1: 1'b0, p2: 4'd0, d2: 1'b0, dn2: 1'b0};
    drive_cycle(-21, 0, 1'b1, 1'b0, e);
    model_frame();
  endtask

  // One scanline: line pulse at sx=-20, scan runs to last_sx; the next line pulse ends it.
  task automatic run_line(input int y, input int last_sx, input bit with_frame);
    bit   act[2], comp[2], fin_now[2];
    int   wend[2];
    exp_t e;
    if (with_frame) model_frame();
    for (int k = 0; k < 2; k++) begin
      wend[k]    = m_sprx + W * scx[k];
      act[k]     = armed && !fin[k] && y >= m_spry && y < m_spry + H * scy[k] &&
                   (m_sprx - 2 >= -18);
      comp[k]    = act[k] && last_sx >= wend[k] - 2;
      fin_now[k] = comp[k] && mrep[k] == scy[k] - 1 && mrow[k] == H - 1;
    end
    for (int x = -20; x <= last_sx; x++) begin
      logic [3:0] p[2];
      bit         dn[2];
      for (int k = 0; k < 2; k++) begin
        p[k]  = 4'd0;
        if (x == -20 && carry_col[k] >= 0) p[k] = exp_pix(carry_row[k], carry_col[k]);
        else if (act[k] && x >= m_sprx && x < wend[k])
          p[k] = exp_pix(mrow[k], (x - m_sprx) / scx[k]);
        dn[k] = fin_now[k] && x == wend[k];
      end
      e.p1 = p[0]; e.d1 = (p[0] != 0); e.dn1 = dn[0];
      e.p2 = p[1]; e.d2 = (p[1] != 0); e.dn2 = dn[1];
      drive_cycle(x, y, with_frame && x == -20, x == -20, e);
    end
    for (int k = 0; k < 2; k++) begin
      carry_col[k] = -1;
      if (act[k] && last_sx >= m_sprx - 1 && last_sx <= wend[k] - 2) begin
        carry_col[k] = (last_sx + 1 - m_sprx) / scx[k];
        carry_row[k] = mrow[k];
      end
      if (comp[k]) begin
        if (mrep[k] == scy[k] - 1) begin
          mrep[k] = 0;
          if (mrow[k] == H - 1) fin[k] = 1'b1;
          else mrow[k]++;
        end else begin
          mrep[k]++;
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string when);
    check({when, ".pix1"}, pix1, 0);
    check({when, ".drawing1"}, drw1, 0);
    check({when, ".done1"}, done1, 0);
    check({when, ".addr1"}, addr1, 0);
    check({when, ".pix2"}, pix2, 0);
    check({when, ".drawing2"}, drw2, 0);
    check({when, ".done2"}, done2, 0);
    check({when, ".addr2"}, addr2, 0);
  endtask

  initial begin
    carry_col = '{-1, -1};
    carry_row = '{0, 0};
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame: 1x1 rows 50..57, 2x3 rows 50..73, each with one done pulse.
    set_pos(100, 50, 1'b0);
    do_frame();
    for (int y = 48; y <= 75; y++) run_line(y, 119, 1'b0);

    // Frame coincident with line, then a line abandoned mid-draw.
    run_line(50, 119, 1'b1);
    run_line(51, 102, 1'b0);
    run_line(52, 119, 1'b0);
    run_line(53, 119, 1'b0);

    // Far-left sprite: address slot falls before the line can reach WAIT_POS.
    set_pos(-17, 10, 1'b0);
    do_frame();
    run_line(10, 119, 1'b0);
    run_line(11, 119, 1'b0);

    // Earliest reachable left edge.
    set_pos(-16, 10, 1'b0);
    do_frame();
    run_line(10, 119, 1'b0);
    run_line(11, 119, 1'b0);

    // Mirrored sprite (plain when the flip feature is not built), then reset mid-draw.
    set_pos(100, 50, 1'b1);
    do_frame();
    for (int y = 50; y <= 52; y++) run_line(y, 119, 1'b0);
    run_line(53, 103, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    armed     = 1'b0;
    carry_col = '{-1, -1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Nothing drawn until a frame re-arms the renderer.
    run_line(54, 119, 1'b0);
    set_pos(100, 50, 1'b0);
    do_frame();
    run_line(50, 119, 1'b0);
    run_line(51, 119, 1'b0);

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
